// File: rtl/wrr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_packet_arbiter
//
// Weighted round-robin arbiter that grants whole packets. Once a requester
// wins, it keeps the grant until its last beat transfers, the owner stops
// presenting beats for TIMEOUT cycles, or reset. A winner may keep priority
// for up to its weight in consecutive packets before the pointer advances.
//
// Parameters
//   N         number of requesters (>= 2)
//   WEIGHT_W  width of each per-requester weight
//   TIMEOUT   consecutive owner-idle cycles tolerated before abort (>= 1)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req          per-requester beat valid
//   req_last     per-requester last-beat marker
//   weights      packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
//   out_ready    downstream accepts a beat this cycle
//   grants       one-hot grant (registered)
//   grant_id     binary index of the owner (registered)
//   locked       a packet is in progress (registered)
//   timeout_err  one-cycle pulse when a packet is aborted (registered)
// -----------------------------------------------------------------------------
module wrr_packet_arbiter #(
   parameter int N        = 4,
   parameter int WEIGHT_W = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            req_last,
   input  logic [N*WEIGHT_W-1:0]   weights,
   input  logic                    out_ready,
   output logic [N-1:0]            grants,
   output logic [$clog2(N)-1:0]    grant_id,
   output logic                    locked,
   output logic                    timeout_err
);

   localparam int IDW = $clog2(N);
   localparam int SW  = $clog2(TIMEOUT + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [IDW-1:0]      ptr_r;
   logic [IDW-1:0]      ptr_s;
   logic [IDW-1:0]      owner_r;
   logic [IDW-1:0]      owner_s;
   logic [WEIGHT_W-1:0] credit_r;
   logic [WEIGHT_W-1:0] credit_s;
   logic [WEIGHT_W-1:0] credit_dec_s;
   logic [SW-1:0]       stall_r;
   logic [SW-1:0]       stall_s;
   logic                timeout_s;
   logic [IDW-1:0]      winner_s;
   logic                owner_req_s;
   logic                owner_last_s;

   // Index increment that wraps N-1 -> 0, also for non-power-of-2 N.
   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
      logic [IDW-1:0] res;
      if (idx == IDW'(N - 1)) begin
         res = '0;
      end else begin
         res = idx + IDW'(1);
      end
      return res;
   endfunction

   // A programmed weight of zero still grants one packet per round.
   function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
      logic [WEIGHT_W-1:0] res;
      if (w == '0) begin
         res = WEIGHT_W'(1);
      end else begin
         res = w;
      end
      return res;
   endfunction

   // Extract the packed weight of one requester.
   function automatic logic [WEIGHT_W-1:0] weight_of(input logic [N*WEIGHT_W-1:0] ws,
                                                     input logic [IDW-1:0]        idx);
      logic [WEIGHT_W-1:0] res;
      res = '0;
      for (int i = 0; i < N; i++) begin
         if (IDW'(i) == idx) begin
            res = ws[i*WEIGHT_W +: WEIGHT_W];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
      return {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction

   // First requester with req set, scanning cyclically upward from p.
   function automatic logic [IDW-1:0] pick_winner(input logic [N-1:0]   r,
                                                  input logic [IDW-1:0] p);
      logic [IDW-1:0] res;
      logic [IDW-1:0] cand;
      logic           found;
      res   = p;
      cand  = p;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && r[cand]) begin
            res   = cand;
            found = 1'b1;
         end else begin
            found = found;
         end
         cand = next_idx(cand);
      end
      return res;
   endfunction

   assign winner_s     = pick_winner(req, ptr_r);
   assign owner_req_s  = req[owner_r];
   assign owner_last_s = req_last[owner_r];
   assign credit_dec_s = credit_r - WEIGHT_W'(1);

   // Next-state logic: arbitration, packet end, and stall timeout.
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      owner_s   = owner_r;
      credit_s  = credit_r;
      stall_s   = stall_r;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req != '0) begin
               state_s = LOCKED;
               owner_s = winner_s;
               stall_s = '0;
               // The previous owner re-winning with credit left keeps its credit.
               if ((winner_s != ptr_r) || (credit_r == '0)) begin
                  credit_s = eff_weight(weight_of(weights, winner_s));
               end else begin
                  credit_s = credit_r;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOCKED: begin
            if (owner_req_s) begin
               stall_s = '0;
               if (out_ready && owner_last_s) begin
                  state_s  = IDLE;
                  credit_s = credit_dec_s;
                  if (credit_dec_s == '0) begin
                     ptr_s = next_idx(owner_r);
                  end else begin
                     ptr_s = owner_r;
                  end
               end else begin
                  state_s = LOCKED;
               end
            end else if (stall_r == SW'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th consecutive idle cycle of the owner.
               state_s   = IDLE;
               timeout_s = 1'b1;
               credit_s  = '0;
               ptr_s     = next_idx(owner_r);
               stall_s   = '0;
            end else begin
               stall_s = stall_r + SW'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         ptr_r    <= '0;
         owner_r  <= '0;
         credit_r <= '0;
         stall_r  <= '0;
      end else begin
         state_r  <= state_s;
         ptr_r    <= ptr_s;
         owner_r  <= owner_s;
         credit_r <= credit_s;
         stall_r  <= stall_s;
      end
   end

   // Output registers, loaded from next-state values so they track state_r.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grants      <= '0;
         grant_id    <= '0;
         locked      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (state_s == LOCKED) begin
            grants   <= onehot(owner_s);
            grant_id <= owner_s;
            locked   <= 1'b1;
         end else begin
            grants   <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
         end
         timeout_err <= timeout_s;
      end
   end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for wrr_packet_arbiter (N=4, WEIGHT_W=4,
// TIMEOUT=16). Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_wrr_packet_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  req_last;
   logic [15:0] weights;
   logic        out_ready;
   logic [3:0]  grants;
   logic [1:0]  grant_id;
   logic        locked;
   logic        timeout_err;

   int compared   = 0;
   int mismatched = 0;

   wrr_packet_arbiter #(
      .N        (4),
      .WEIGHT_W (4),
      .TIMEOUT  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_last    (req_last),
      .weights     (weights),
      .out_ready   (out_ready),
      .grants      (grants),
      .grant_id    (grant_id),
      .locked      (locked),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = 4'b0000;
      req_last  = 4'b0000;
      out_ready = 1'b0;
      weights   = 16'h1111;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if (grants !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_grants: got %b expected 0000", grants);
      end
      compared++;
      if (grant_id !== 2'd0) begin
         mismatched++;
         $display("FAIL reset_grant_id: got %0d expected 0", grant_id);
      end
      compared++;
      if (locked !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_locked: got %b expected 0", locked);
      end
      compared++;
      if (timeout_err !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
      end
   endtask

   // All request, weights 1, single-beat packets: plain rotation with bubbles.
   task automatic test_round_robin();
      logic [3:0] exp_g  [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      logic [1:0] exp_id [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
      do_reset();
      weights   = 16'h1111;
      req       = 4'b1111;
      req_last  = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         compared++;
         if (grants !== exp_g[i]) begin
            mismatched++;
            $display("FAIL rr_grants[%0d]: got %b expected %b", i, grants, exp_g[i]);
         end
         compared++;
         if (grant_id !== exp_id[i] || locked !== (exp_g[i] != 4'b0000)) begin
            mismatched++;
            $display("FAIL rr_id_locked[%0d]: got id=%0d locked=%b expected id=%0d locked=%b",
                     i, grant_id, locked, exp_id[i], (exp_g[i] != 4'b0000));
         end
      end
   endtask

   // Requester 0 weight 3 wins three packets in a row, then 1, 2, 3, 0.
   // weight_zero uses weight 0 for requester 2, which must behave as 1.
   task automatic test_weighted(input logic [15:0] w, input logic [1:0] exp_win [8],
                                input string name);
      do_reset();
      weights   = w;
      req       = 4'b1111;
      req_last  = 4'b1111;
      out_ready = 1'b1;
      for (int p = 0; p < 8; p++) begin
         tick();
         compared++;
         if (grant_id !== exp_win[p] || grants !== (4'b0001 << exp_win[p]) || locked !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_pkt[%0d]: got id=%0d grants=%b locked=%b expected id=%0d",
                     name, p, grant_id, grants, locked, exp_win[p]);
         end
         tick();
         compared++;
         if (grants !== 4'b0000) begin
            mismatched++;
            $display("FAIL %s_bubble[%0d]: got %b expected 0000", name, p, grants);
         end
      end
   endtask

   // Four-beat packet from requester 2 with out_ready toggling; requester 1
   // (and its req_last) must be ignored until the last beat is accepted.
   task automatic test_multibeat_hold();
      do_reset();
      weights   = 16'h1111;
      req       = 4'b0100;
      tick();
      compared++;
      if (grants !== 4'b0100) begin
         mismatched++;
         $display("FAIL hold_start: got %b expected 0100", grants);
      end
      req = 4'b0110;
      for (int k = 0; k < 7; k++) begin
         out_ready = (k % 2 == 0);
         req_last  = (k >= 5) ? 4'b0110 : 4'b0010;
         tick();
         compared++;
         if (k < 6 && grants !== 4'b0100) begin
            mismatched++;
            $display("FAIL hold_beat[%0d]: got %b expected 0100", k, grants);
         end else if (k == 6 && grants !== 4'b0000) begin
            mismatched++;
            $display("FAIL hold_end: got %b expected 0000", grants);
         end
      end
      req_last  = 4'b0000;
      tick();
      compared++;
      if (grants !== 4'b0010 || grant_id !== 2'd1) begin
         mismatched++;
         $display("FAIL hold_next: got grants=%b id=%0d expected 0010 id=1", grants, grant_id);
      end
   endtask

   // Owner holding req while out_ready is low must never time out.
   task automatic test_ready_stall();
      logic seen;
      do_reset();
      req       = 4'b0001;
      req_last  = 4'b0001;
      out_ready = 1'b0;
      seen      = 1'b0;
      for (int i = 0; i < 21; i++) begin
         tick();
         seen = seen | timeout_err;
      end
      compared++;
      if (locked !== 1'b1 || seen !== 1'b0) begin
         mismatched++;
         $display("FAIL ready_stall: got locked=%b timeout_seen=%b expected locked=1 seen=0",
                  locked, seen);
      end
      out_ready = 1'b1;
      tick();
      compared++;
      if (locked !== 1'b0) begin
         mismatched++;
         $display("FAIL ready_stall_end: got locked=%b expected 0", locked);
      end
   endtask

   // Owner 1 drops req for 16 cycles: abort, then search from requester 2.
   task automatic test_timeout();
      do_reset();
      req       = 4'b0010;
      req_last  = 4'b0000;
      out_ready = 1'b1;
      tick();
      tick();
      req = 4'b1101;
      for (int i = 1; i <= 15; i++) begin
         tick();
         compared++;
         if (locked !== 1'b1 || timeout_err !== 1'b0 || grants !== 4'b0010) begin
            mismatched++;
            $display("FAIL to_wait[%0d]: got locked=%b err=%b grants=%b expected 1 0 0010",
                     i, locked, timeout_err, grants);
         end
      end
      tick();
      compared++;
      if (timeout_err !== 1'b1 || locked !== 1'b0 || grants !== 4'b0000) begin
         mismatched++;
         $display("FAIL to_fire: got err=%b locked=%b grants=%b expected 1 0 0000",
                  timeout_err, locked, grants);
      end
      tick();
      compared++;
      if (timeout_err !== 1'b0 || grants !== 4'b0100 || grant_id !== 2'd2) begin
         mismatched++;
         $display("FAIL to_next: got err=%b grants=%b id=%0d expected 0 0100 2",
                  timeout_err, grants, grant_id);
      end
   endtask

   // Asynchronous reset mid-packet, then arbitration restarts at requester 0.
   task automatic test_async_reset();
      do_reset();
      req       = 4'b1000;
      req_last  = 4'b0000;
      out_ready = 1'b1;
      tick();
      compared++;
      if (grants !== 4'b1000 || grant_id !== 2'd3) begin
         mismatched++;
         $display("FAIL ar_owner: got grants=%b id=%0d expected 1000 3", grants, grant_id);
      end
      #2;
      rst = 1'b1;
      #1;
      compared++;
      if (grants !== 4'b0000 || locked !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin
         mismatched++;
         $display("FAIL ar_async: got grants=%b locked=%b id=%0d err=%b expected all 0",
                  grants, locked, grant_id, timeout_err);
      end
      tick();
      rst = 1'b0;
      req = 4'b1010;
      tick();
      compared++;
      if (grants !== 4'b0010 || grant_id !== 2'd1) begin
         mismatched++;
         $display("FAIL ar_restart: got grants=%b id=%0d expected 0010 1", grants, grant_id);
      end
   endtask

   initial begin
      logic [1:0] exp_w3 [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
      logic [1:0] exp_w0 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      rst       = 1'b1;
      req       = 4'b0000;
      req_last  = 4'b0000;
      weights   = 16'h1111;
      out_ready = 1'b0;
      test_reset();
      test_round_robin();
      test_weighted(16'h1113, exp_w3, "weight3");
      test_multibeat_hold();
      test_ready_stall();
      test_timeout();
      test_async_reset();
      test_weighted(16'h1011, exp_w0, "weight_zero");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wrr_packet_arbiter.md
WRR_PACKET_ARBITER -- requirements
Module: wrr_packet_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter WEIGHT_W, default 4, giving the width of each per-requester weight.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the stall cycles tolerated before a packet is aborted (TIMEOUT >= 1).
REQ-004 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port req, input, N bits: per-requester beat-valid.
REQ-007 Port req_last, input, N bits: marks the requester's current beat as the last beat of its packet.
REQ-008 Port weights, input, N*WEIGHT_W bits: packed weights, requester i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-009 Port out_ready, input, 1 bit: the downstream accepts a beat this cycle.
REQ-010 Port grants, output, N bits: one-hot grant, registered.
REQ-011 Port grant_id, output, $clog2(N) bits: binary index of the owner, registered.
REQ-012 Port locked, output, 1 bit: a packet is in progress.
REQ-013 Port timeout_err, output, 1 bit: one-cycle pulse when a packet is aborted.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and LOCKED.
REQ-015 In IDLE with req != 0, the winner SHALL be the first requester with req set, searching cyclically from ptr upward; the next state is LOCKED with owner = winner.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE with ptr and credit unchanged.
REQ-017 In LOCKED, grants SHALL equal onehot(owner), grant_id SHALL equal owner, and locked SHALL be 1; in IDLE all three SHALL be 0.
REQ-018 The grant output SHALL have one cycle of latency: the first cycle a beat can transfer is the cycle after the IDLE cycle in which the winner was selected.
REQ-019 A beat SHALL transfer in a cycle when all of the following are 1: LOCKED, req[owner] and out_ready.
REQ-020 req and req_last of non-owners SHALL be ignored while LOCKED; the grant SHALL NOT change mid-packet.
REQ-021 A transfer with req_last[owner] = 1 SHALL end the packet, and the next state SHALL be IDLE (exactly one bubble cycle between packets).
REQ-022 The effective weight SHALL be weights[i], or 1 when weights[i] = 0.
REQ-023 On selection, credit SHALL be loaded with the winner's effective weight when winner != ptr or credit == 0; otherwise credit SHALL be kept.
REQ-024 At packet end, credit SHALL decrement by 1.
REQ-025 At packet end, if the decremented credit is 0, ptr SHALL become (owner+1) mod N; otherwise ptr SHALL become owner, so the owner retains priority for up to weight packets.
REQ-026 ptr arithmetic SHALL wrap from N-1 to 0, including for non-power-of-2 N.
REQ-027 A stall counter SHALL count LOCKED cycles with req[owner] = 0.
REQ-028 The stall counter SHALL clear on any cycle with req[owner] = 1 and on entry to LOCKED.
REQ-029 out_ready = 0 with req[owner] = 1 SHALL NOT count as a stall cycle.
REQ-030 When the stall counter reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle, go to IDLE, set credit = 0 and set ptr = (owner+1) mod N.
REQ-031 If a last-beat transfer and a timeout occur in the same cycle, the transfer SHALL win and no timeout_err SHALL be raised.
REQ-032 Changes to weights SHALL take effect only at the next credit load.

Reset
REQ-033 While rst = 1, the block SHALL hold state = IDLE, ptr = 0, credit = 0, owner = 0, stall counter = 0, and grants, grant_id, locked and timeout_err = 0, regardless of clk.
REQ-034 rst asserted mid-packet SHALL abort the packet without a timeout_err pulse.
REQ-035 After rst deasserts, the first arbitration SHALL search from requester 0.

Verification (N=4, WEIGHT_W=4, TIMEOUT=16)
REQ-036 Scenario 1: req = 4'b1111 continuously, weights all 1, every beat last, out_ready = 1 -> grants sequence 0001,0010,0100,1000,0001, with one idle cycle between each.
REQ-037 Scenario 2: weights = {1,1,1,3} (requester 0 weight 3), all requesting single-beat packets -> requester 0 wins 3 consecutive packets, then 1, 2 and 3 each win once.
REQ-038 Scenario 3: requester 2 sends a 4-beat packet while req[1] is set and out_ready toggles 1,0,1,0 -> grants stays 0100 for all beats; the grant moves to 0010 only after the last beat is accepted.
REQ-039 Scenario 4: owner 1 drops req for 16 cycles mid-packet -> timeout_err pulses once, locked falls, and the next winner is searched from ptr = 2.
REQ-040 Scenario 5: rst asserted during LOCKED with owner 3 -> grants = 0 immediately; after release with req = 4'b1010, requester 1 wins first.
REQ-041 Scenario 6: a weight of 0 programmed for requester 2 -> requester 2 gets exactly one packet per round.
